// File: rtl/mem_ctrl.sv
// Single-port synchronous RAM with a valid/ready request port, a fixed-latency
// response port and a built-in clear engine that zeroes the array after reset
// or on command.
module mem_ctrl #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned OUT_REG    = 0,
  parameter int unsigned INIT_CLEAR = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  input  logic              clr_start_i,
  output logic              busy_o
);

  localparam int unsigned CntW = ADDR_W + 1;
  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);
  localparam logic [CntW-1:0] LastC  = CntW'(DEPTH - 1);

  typedef enum logic [0:0] {StClear, StReady} state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic              busy_q;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              accept;
  logic              in_range;
  logic [IdxW-1:0]   addr_idx;
  logic [IdxW-1:0]   cnt_idx;
  logic [DATA_W-1:0] rd_word;

  logic              v1_q;
  logic              e1_q;
  logic [DATA_W-1:0] d1_q;

  // Request handshake and address decode; a clear command takes priority.
  always_comb begin
    req_ready_o = (state_q == StReady) && !clr_start_i;
    accept      = req_valid_i && req_ready_o;
    in_range    = {1'b0, req_addr_i} < DepthC;
    // Truncation is safe: the index is only used when the address is in range.
    addr_idx    = req_addr_i[IdxW-1:0];
    cnt_idx     = cnt_q[IdxW-1:0];
    rd_word     = in_range ? mem_q[addr_idx] : '0;
  end

  // Clear/ready state machine with registered busy flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= (INIT_CLEAR != 0) ? StClear : StReady;
      cnt_q   <= '0;
      busy_q  <= (INIT_CLEAR != 0);
    end else begin
      unique case (state_q)
        StClear: begin
          if (cnt_q == LastC) begin
            state_q <= StReady;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StReady: begin
          if (clr_start_i) begin
            state_q <= StClear;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= StReady;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Storage array; deliberately not reset, the clear engine zeroes it.
  always_ff @(posedge clk_i) begin
    if (state_q == StClear) begin
      mem_q[cnt_idx] <= '0;
    end else if (accept && req_we_i && in_range) begin
      mem_q[addr_idx] <= req_wdata_i;
    end
  end

  // First response stage: writes echo their data, reads see pre-write contents.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v1_q <= 1'b0;
      e1_q <= 1'b0;
      d1_q <= '0;
    end else begin
      v1_q <= accept;
      e1_q <= accept && !in_range;
      if (accept) begin
        d1_q <= req_we_i ? (in_range ? req_wdata_i : '0) : rd_word;
      end
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic              v2_q;
    logic              e2_q;
    logic [DATA_W-1:0] d2_q;

    // Optional second stage; data holds while no response is presented.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        v2_q <= 1'b0;
        e2_q <= 1'b0;
        d2_q <= '0;
      end else begin
        v2_q <= v1_q;
        e2_q <= v1_q && e1_q;
        if (v1_q) begin
          d2_q <= d1_q;
        end
      end
    end

    assign rsp_valid_o = v2_q;
    assign rsp_err_o   = e2_q;
    assign rsp_rdata_o = d2_q;
  end else begin : g_no_out_reg
    assign rsp_valid_o = v1_q;
    assign rsp_err_o   = e1_q;
    assign rsp_rdata_o = d1_q;
  end

  assign busy_o = busy_q;

endmodule
